// File: rtl/peb_bus_pkg.sv
// rtl/peb_bus_pkg.sv - op encodings, FSM states and bus constants for the PEB bus master
package peb_bus_pkg;

  typedef enum logic [1:0] {
    MEM_RD  = 2'd0,
    MEM_WR  = 2'd1,
    CRU_OUT = 2'd2,
    CRU_IN  = 2'd3
  } peb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STROBE,
    ST_WAIT,
    ST_DONE
  } peb_state_e;

  // Value returned for a memory read nobody answered.
  localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

  function automatic logic is_mem_op(input peb_op_e op);
    return (op == MEM_RD) || (op == MEM_WR);
  endfunction

endpackage

// File: rtl/peb_bus_wait_timer.sv
// rtl/peb_bus_wait_timer.sv - minimum wait-state counter plus optional timeout counter
// Timeout counter exists only when PEB_BUS_MASTER_TIMEOUT_EN is defined.
module peb_bus_wait_timer #(
  parameter int WAIT_MIN      = 2,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_tick,
  input  logic i_ready,
  output logic o_expired,
  output logic o_timeout
);

  logic [3:0] r_min_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_min_cnt <= '0;
    end else if (i_load) begin
      r_min_cnt <= 4'(WAIT_MIN);
    end else if (i_tick && (r_min_cnt != 4'd0)) begin
      r_min_cnt <= r_min_cnt - 4'd1;
    end
  end

  // Expired means the current tick is the one that brings the count to zero (or later).
  assign o_expired = (r_min_cnt <= 4'd1);

`ifdef PEB_BUS_MASTER_TIMEOUT_EN
  logic [7:0] r_to_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_to_cnt <= '0;
    end else if (i_load) begin
      r_to_cnt <= '0;
    end else if (i_tick && o_expired && !i_ready && (r_to_cnt != 8'(TIMEOUT_TICKS))) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  assign o_timeout = (r_to_cnt == 8'(TIMEOUT_TICKS));
`else
  // Without the timeout, ready and the limit have no consumer here.
  logic w_unused_to;
  assign w_unused_to = i_ready ^ (TIMEOUT_TICKS == 0);
  assign o_timeout   = 1'b0;
`endif

endmodule

// File: rtl/peb_bus_master.sv
// rtl/peb_bus_master.sv - PEB bus initiator turning queued requests into tick-paced bus cycles
// Optional wait-state timeout enabled by PEB_BUS_MASTER_TIMEOUT_EN.
module peb_bus_master
  import peb_bus_pkg::*;
#(
  parameter int WAIT_MIN      = 2,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_clk_en,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [0:15] i_req_addr,
  input  logic [0:7]  i_req_data,
  output logic        o_rsp_valid,
  output logic [0:7]  o_rsp_data,
  output logic        o_rsp_err,
  output logic [0:15] o_a,
  output logic [0:7]  o_d,
  output logic        o_memen,
  output logic        o_dbin,
  output logic        o_we,
  output logic        o_cruclk,
  input  logic [0:7]  i_q,
  input  logic        i_cruin,
  input  logic        i_ready
);

  peb_state_e  r_state;
  peb_op_e     r_op;
  logic [0:15] r_addr;
  logic [0:7]  r_data;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [0:7]  r_rsp_data;
  logic        r_rsp_err;
  logic [0:15] r_a;
  logic [0:7]  r_d;
  logic        r_memen, r_dbin, r_we, r_cruclk;

  logic w_load, w_wait_tick, w_expired, w_timeout;

  assign w_load      = i_cpu_clk_en && (r_state == ST_STROBE) && is_mem_op(r_op);
  assign w_wait_tick = i_cpu_clk_en && (r_state == ST_WAIT);

  peb_bus_wait_timer #(
    .WAIT_MIN      (WAIT_MIN),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_tick    (w_wait_tick),
    .i_ready   (i_ready),
    .o_expired (w_expired),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_op        <= MEM_RD;
      r_addr      <= '0;
      r_data      <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_a         <= '0;
      r_d         <= '0;
      r_memen     <= 1'b0;
      r_dbin      <= 1'b0;
      r_we        <= 1'b0;
      r_cruclk    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_req_ready && i_req_valid) begin
            r_op        <= peb_op_e'(i_req_op);
            r_addr      <= i_req_addr;
            r_data      <= i_req_data;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b0;
            r_state     <= ST_ADDR;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_ADDR: if (i_cpu_clk_en) begin
          r_a     <= r_addr;
          r_d     <= r_data;
          r_memen <= is_mem_op(r_op);
          r_dbin  <= (r_op == MEM_RD);
          r_state <= ST_STROBE;
        end
        ST_STROBE: if (i_cpu_clk_en) begin
          case (r_op)
            MEM_WR: begin
              r_we    <= 1'b1;
              r_state <= ST_WAIT;
            end
            CRU_OUT: begin
              r_cruclk   <= 1'b1;
              r_rsp_data <= '0;
              r_state    <= ST_DONE;
            end
            CRU_IN: begin
              r_rsp_data <= {7'b0, i_cruin};
              r_state    <= ST_DONE;
            end
            default: r_state <= ST_WAIT;
          endcase
        end
        ST_WAIT: if (i_cpu_clk_en && w_expired) begin
          // ready wins over a simultaneous timeout.
          if (i_ready) begin
            r_rsp_data <= (r_op == MEM_RD) ? i_q : 8'h00;
            r_state    <= ST_DONE;
          end else if (w_timeout) begin
            r_rsp_data <= (r_op == MEM_RD) ? BUS_IDLE_DATA : 8'h00;
            r_rsp_err  <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_memen     <= 1'b0;
          r_dbin      <= 1'b0;
          r_we        <= 1'b0;
          r_cruclk    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_a         = r_a;
  assign o_d         = r_d;
  assign o_memen     = r_memen;
  assign o_dbin      = r_dbin;
  assign o_we        = r_we;
  assign o_cruclk    = r_cruclk;

endmodule

// File: tb/tb_peb_bus_master.sv
// tb/tb_peb_bus_master.sv - self-checking bench for peb_bus_master with a tick-counting reference model
module tb_peb_bus_master;

  localparam int WAIT_MIN = 2;
  localparam int TO_TICKS = 4;
  localparam int OP_RD = 0, OP_WR = 1, OP_CO = 2, OP_CI = 3;

  logic        clk = 0, rst = 0, cpu_clk_en = 0, req_valid = 0;
  logic [1:0]  req_op = 0;
  logic [0:15] req_addr = 0;
  logic [0:7]  req_data = 0, q = 0;
  logic        cruin = 0, ready = 1;

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_memen, o_dbin, o_we, o_cruclk;
  logic [0:7]  o_rsp_data, o_d;
  logic [0:15] o_a;

  peb_bus_master #(.WAIT_MIN(WAIT_MIN), .TIMEOUT_TICKS(TO_TICKS)) dut (
    .i_clk(clk), .i_reset(rst), .i_cpu_clk_en(cpu_clk_en),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_op(req_op),
    .i_req_addr(req_addr), .i_req_data(req_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_a(o_a), .o_d(o_d), .o_memen(o_memen), .o_dbin(o_dbin), .o_we(o_we),
    .o_cruclk(o_cruclk), .i_q(q), .i_cruin(cruin), .i_ready(ready)
  );

  always #5 clk = ~clk;

  int clk_n = 0;
  int tick_div = 1;
  always @(posedge clk) clk_n++;

  initial forever begin
    @(posedge clk); #1;
    cpu_clk_en = (tick_div <= 1) ? 1'b1 : ((clk_n % tick_div) == 0);
  end

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts bus ticks since acceptance and applies the cycle rules directly.
  logic        e_req_ready, e_memen, e_dbin, e_we, e_cruclk, e_rsp_valid, e_rsp_err;
  logic [0:15] e_a, m_addr;
  logic [0:7]  e_d, e_rsp_data, m_data, m_result;
  logic        m_err;
  bit          m_busy, m_release;
  int          m_ticks, m_op;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_req_ready = 0; e_memen = 0; e_dbin = 0; e_we = 0; e_cruclk = 0;
      e_rsp_valid = 0; e_rsp_err = 0; e_a = 0; e_d = 0; e_rsp_data = 0;
      m_busy = 0; m_release = 0; m_ticks = 0; m_err = 0; m_result = 0;
    end else begin
      e_rsp_valid = 0;
      if (!m_busy) begin
        if (e_req_ready && req_valid) begin
          m_op = int'(req_op); m_addr = req_addr; m_data = req_data;
          m_busy = 1; m_ticks = 0; e_req_ready = 0;
        end else begin
          e_req_ready = 1;
        end
      end else if (m_release) begin
        e_memen = 0; e_dbin = 0; e_we = 0; e_cruclk = 0;
        e_rsp_valid = 1; e_rsp_data = m_result; e_rsp_err = m_err;
        e_req_ready = 1; m_busy = 0; m_release = 0;
      end else if (cpu_clk_en) begin
        m_ticks++;
        if (m_ticks == 1) begin
          e_a = m_addr; e_d = m_data;
          e_memen = (m_op == OP_RD || m_op == OP_WR);
          e_dbin = (m_op == OP_RD);
        end else if (m_ticks == 2) begin
          if (m_op == OP_WR) e_we = 1;
          if (m_op == OP_CO) begin e_cruclk = 1; m_result = 8'h00; m_err = 0; m_release = 1; end
          if (m_op == OP_CI) begin m_result = {7'b0, cruin}; m_err = 0; m_release = 1; end
        end else if (m_ticks >= WAIT_MIN + 2) begin
          if (ready) begin
            m_result = (m_op == OP_RD) ? q : 8'h00; m_err = 0; m_release = 1;
          end
`ifdef PEB_BUS_MASTER_TIMEOUT_EN
          else if (m_ticks == WAIT_MIN + 2 + TO_TICKS) begin
            m_result = (m_op == OP_RD) ? 8'hFF : 8'h00; m_err = 1; m_release = 1;
          end
`endif
        end
      end
    end
  end

  int cnt_memen, cnt_dbin, cnt_we, cnt_cruclk, cnt_rsp, cnt_we_bad_d;
  logic [0:15] cap_a;
  logic [0:7]  cap_d;

  always @(negedge clk) begin
    chk("req_ready", o_req_ready, e_req_ready);
    chk("a", o_a, e_a);
    chk("d", o_d, e_d);
    chk("memen", o_memen, e_memen);
    chk("dbin", o_dbin, e_dbin);
    chk("we", o_we, e_we);
    chk("cruclk", o_cruclk, e_cruclk);
    chk("rsp_valid", o_rsp_valid, e_rsp_valid);
    if (e_rsp_valid) begin
      chk("rsp_data", o_rsp_data, e_rsp_data);
      chk("rsp_err", o_rsp_err, e_rsp_err);
    end
    if (o_memen) cnt_memen++;
    if (o_dbin) cnt_dbin++;
    if (o_we) begin cnt_we++; if (o_d != 8'hC3) cnt_we_bad_d++; end
    if (o_cruclk) begin cnt_cruclk++; cap_a = o_a; cap_d = o_d; end
    if (o_rsp_valid) cnt_rsp++;
  end

  task automatic clr_cnt();
    cnt_memen = 0; cnt_dbin = 0; cnt_we = 0; cnt_cruclk = 0; cnt_rsp = 0; cnt_we_bad_d = 0;
  endtask

  int acc_clk;
  task automatic issue(input int op, input logic [0:15] addr, input logic [0:7] data);
    int n = 0;
    req_valid = 1; req_op = op[1:0]; req_addr = addr; req_data = data;
    while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", o_req_ready, 1);
    @(posedge clk); #1;
    acc_clk = clk_n;
    req_valid = 0; req_op = 0; req_addr = 0; req_data = 0;
  endtask

  task automatic wait_rsp(input int budget, output int lat, output int rsp_clk,
                          output logic [0:7] data, output logic err);
    int n = 0;
    bit got = 0;
    lat = -1; rsp_clk = -1; data = 0; err = 0;
    while (!got && n < budget) begin
      @(negedge clk); n++;
      if (o_rsp_valid) begin
        got = 1; lat = clk_n - acc_clk; rsp_clk = clk_n; data = o_rsp_data; err = o_rsp_err;
      end
    end
    chk("rsp_seen", got, 1);
  endtask

  task automatic wait_model_ticks(input int n);
    int c = 0;
    while (m_ticks < n && c < 300) begin @(posedge clk); #1; c++; end
    chk("tick_wait", (m_ticks >= n), 1);
  endtask

  int lat, rclk, rclk1;
  logic [0:7] rdata;
  logic rerr;

  initial begin
    #1 rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", o_req_ready, 0);
    chk("reset_memen", o_memen, 0);
    chk("reset_a", o_a, 0);
    chk("reset_rsp_valid", o_rsp_valid, 0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk); #1;

    // MEM_RD, ready high, tick every clk
    tick_div = 1; ready = 1; q = 8'h5A; clr_cnt();
    issue(OP_RD, 16'h2000, 8'h00);
    wait_rsp(50, lat, rclk, rdata, rerr);
    chk("rd_latency", lat, 5);
    chk("rd_data", rdata, 8'h5A);
    chk("rd_err", rerr, 0);
    chk("rd_memen_clks", cnt_memen, 4);
    chk("rd_dbin_clks", cnt_dbin, 4);
    chk("rd_we_clks", cnt_we, 0);

    // Back-to-back: second request accepted the clk after rsp_valid
    rclk1 = rclk; q = 8'h3C;
    issue(OP_RD, 16'h2001, 8'h00);
    chk("b2b_gap", acc_clk - rclk1, 1);
    wait_rsp(50, lat, rclk, rdata, rerr);
    chk("b2b_data", rdata, 8'h3C);

    // MEM_WR with ready low for 5 ticks past the minimum, tick every 3 clks
    @(posedge clk); #1;
    tick_div = 3; ready = 0; clr_cnt();
    issue(OP_WR, 16'hA000, 8'hC3);
    wait_model_ticks(WAIT_MIN + 1 + 5);
    chk("wr_no_early_rsp", cnt_rsp, 0);
    chk("wr_we_during_wait", o_we, 1);
    ready = 1;
    wait_rsp(100, lat, rclk, rdata, rerr);
    chk("wr_data", rdata, 8'h00);
    chk("wr_we_clks", cnt_we, 22);
    chk("wr_memen_clks", cnt_memen, 25);
    chk("wr_d_stable", cnt_we_bad_d, 0);

    // CRU_OUT bit=1
    @(posedge clk); #1;
    tick_div = 1; clr_cnt();
    issue(OP_CO, 16'h1100, 8'h01);
    wait_rsp(50, lat, rclk, rdata, rerr);
    chk("co_latency", lat, 3);
    chk("co_cruclk_clks", cnt_cruclk, 1);
    chk("co_addr", cap_a, 16'h1100);
    chk("co_bit", cap_d[7], 1);
    chk("co_memen_clks", cnt_memen, 0);

    // CRU_IN with cruin=1 then cruin=0
    tick_div = 2; cruin = 1; clr_cnt();
    issue(OP_CI, 16'h1102, 8'h00);
    wait_rsp(50, lat, rclk, rdata, rerr);
    chk("ci_data1", rdata, 8'h01);
    chk("ci_memen_clks", cnt_memen, 0);
    chk("ci_dbin_clks", cnt_dbin, 0);
    cruin = 0;
    issue(OP_CI, 16'h1102, 8'h00);
    wait_rsp(50, lat, rclk, rdata, rerr);
    chk("ci_data0", rdata, 8'h00);

    // Reset during WAIT of a MEM_WR
    @(posedge clk); #1;
    tick_div = 1; ready = 0;
    issue(OP_WR, 16'hA000, 8'hC3);
    wait_model_ticks(WAIT_MIN + 3);
    chk("rst_pre_we", o_we, 1);
    rst = 1; #1;
    chk("rst_memen", o_memen, 0);
    chk("rst_we", o_we, 0);
    chk("rst_dbin", o_dbin, 0);
    chk("rst_cruclk", o_cruclk, 0);
    repeat (2) @(posedge clk); #1;
    rst = 0; ready = 1; clr_cnt();
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready_after", o_req_ready, 1);
    repeat (8) @(negedge clk);
    chk("rst_no_rsp", cnt_rsp, 0);

`ifdef PEB_BUS_MASTER_TIMEOUT_EN
    // ready stuck low: timeout after WAIT_MIN+4 wait ticks
    ready = 0; q = 8'h11;
    issue(OP_RD, 16'h2000, 8'h00);
    wait_rsp(60, lat, rclk, rdata, rerr);
    chk("to_latency", lat, 9);
    chk("to_err", rerr, 1);
    chk("to_data", rdata, 8'hFF);
    ready = 1;
`else
    // ready stuck low: the cycle waits with strobes held
    ready = 0; q = 8'hA5; clr_cnt();
    issue(OP_RD, 16'h2000, 8'h00);
    repeat (40) @(negedge clk);
    chk("stuck_no_rsp", cnt_rsp, 0);
    chk("stuck_memen", o_memen, 1);
    chk("stuck_dbin", o_dbin, 1);
    @(posedge clk); #1 ready = 1;
    wait_rsp(20, lat, rclk, rdata, rerr);
    chk("stuck_data", rdata, 8'hA5);
    chk("stuck_err", rerr, 0);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
